jogo_sequencia_param: RTL and testbench

- Parametrised successor to the fixed 4-key, fixed-length memory-game circuit. Control and datapath live in one block.
- Game grows one move per round: round r requires the player to repeat moves 0..r.
- Per-move timeout; invalid (multi-key) presses count as errors.
- Sits under the board top level. Reads the sequence from an external synchronous ROM. Drives leds, the result flags and the debug hex displays.

---
 rtl/jogo_sequencia_param.sv | 186 ++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: parametrised memory game whose sequence grows by one move each round.
// Optional playback of the sequence before each round is enabled with JOGO_MOSTRA_SEQUENCIA_EN.
module jogo_sequencia_param #(
    parameter int N        = 4,
    parameter int DEPTH    = 16,
    parameter int TIMEOUT  = 5000,
    parameter int T_MOSTRA = 1000,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              nivel_jogadas,
    input  logic [N-1:0]      chaves,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_data,
    output logic [N-1:0]      leds,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [ADDR_W-1:0] db_rodada
);
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
    localparam int TW = ($clog2(TIMEOUT) > $clog2(T_MOSTRA + 2) ? $clog2(TIMEOUT) : $clog2(T_MOSTRA + 2)) + 1;
`else
    localparam int TW = $clog2(TIMEOUT) + 1;
`endif
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || T_MOSTRA < 1) begin : g_param_err
        $error("jogo_sequencia_param: invalid parameters");
    end

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        MOSTRA         = 4'h8,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    estado_t           estado_q;
    logic [ADDR_W-1:0] rodada_q, contagem_q, limite_q;
    logic [TW-1:0]     timer_q;
    logic [N-1:0]      jogada_q, leds_q;
    logic              prev_q, pronto_q, acertou_q, errou_q, timeout_q;
    logic              jogada_feita, igual;

    assign jogada_feita = (|chaves) & ~prev_q;
    // a zero or multi-key press can never match a one-hot ROM entry
    assign igual = (jogada_q == mem_data) && (jogada_q != '0) && ((jogada_q & (jogada_q - N'(1))) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            rodada_q   <= '0;
            contagem_q <= '0;
            limite_q   <= '0;
            timer_q    <= '0;
            jogada_q   <= '0;
            leds_q     <= '0;
            prev_q     <= 1'b0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            prev_q <= |chaves;
            case (estado_q)
                INICIAL: begin
                    if (iniciar) estado_q <= PREPARA;
                end
                PREPARA: begin
                    rodada_q   <= '0;
                    contagem_q <= '0;
                    timer_q    <= '0;
                    jogada_q   <= '0;
                    leds_q     <= '0;
                    limite_q   <= nivel_jogadas ? ADDR_W'(DEPTH - 1) : ADDR_W'(DEPTH / 2 - 1);
                    estado_q   <= INICIA_RODADA;
                end
                INICIA_RODADA: begin
                    contagem_q <= '0;
                    timer_q    <= '0;
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
                    leds_q     <= '0;
                    estado_q   <= MOSTRA;
`else
                    estado_q   <= ESPERA;
`endif
                end
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
                MOSTRA: begin
                    // registered leds lag the ROM by one cycle, so the data window runs one cycle past T_MOSTRA
                    timer_q <= timer_q + TW'(1);
                    leds_q  <= (timer_q == '0) ? '0 : mem_data;
                    if (timer_q == TW'(T_MOSTRA + 1)) begin
                        timer_q <= '0;
                        leds_q  <= '0;
                        if (contagem_q == rodada_q) begin
                            contagem_q <= '0;
                            estado_q   <= ESPERA;
                        end else begin
                            contagem_q <= contagem_q + ADDR_W'(1);
                        end
                    end
                end
`endif
                ESPERA: begin
                    timer_q <= timer_q + TW'(1);
                    if (jogada_feita) begin
                        estado_q <= REGISTRA;
                    end else if (timer_q == T_LIM) begin
                        estado_q  <= FIM_TIMEOUT;
                        timeout_q <= 1'b1;
                        pronto_q  <= 1'b1;
                    end
                end
                REGISTRA: begin
                    jogada_q <= chaves;
                    leds_q   <= chaves;
                    estado_q <= COMPARA;
                end
                COMPARA: begin
                    if (!igual) begin
                        estado_q <= FIM_ERRO;
                        errou_q  <= 1'b1;
                        pronto_q <= 1'b1;
                    end else if (contagem_q < rodada_q) begin
                        estado_q <= PROXIMO;
                    end else if (rodada_q == limite_q) begin
                        estado_q  <= FIM_ACERTO;
                        acertou_q <= 1'b1;
                        pronto_q  <= 1'b1;
                    end else begin
                        estado_q <= PROXIMA_RODADA;
                    end
                end
                PROXIMO: begin
                    contagem_q <= contagem_q + ADDR_W'(1);
                    timer_q    <= '0;
                    estado_q   <= ESPERA;
                end
                PROXIMA_RODADA: begin
                    rodada_q <= rodada_q + ADDR_W'(1);
                    estado_q <= INICIA_RODADA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        estado_q   <= PREPARA;
                        pronto_q   <= 1'b0;
                        acertou_q  <= 1'b0;
                        errou_q    <= 1'b0;
                        timeout_q  <= 1'b0;
                        rodada_q   <= '0;
                        contagem_q <= '0;
                        timer_q    <= '0;
                        jogada_q   <= '0;
                        leds_q     <= '0;
                    end
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign mem_addr    = contagem_q;
    assign leds        = leds_q;
    assign pronto      = pronto_q;
    assign acertou     = acertou_q;
    assign errou       = errou_q;
    assign timeout     = timeout_q;
    assign db_estado   = estado_q;
    assign db_contagem = contagem_q;
    assign db_rodada   = rodada_q;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb_jogo_sequencia_param: directed checks of the memory game with DEPTH=4 and TIMEOUT=8.
module tb_jogo_sequencia_param;
    localparam int N = 4, DEPTH = 4, AW = 2;

    logic          clock = 1'b0;
    logic          reset, iniciar, nivel_jogadas;
    logic [N-1:0]  chaves, mem_data, leds;
    logic [AW-1:0] mem_addr, db_contagem, db_rodada;
    logic          pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;
    logic [N-1:0]  rom [DEPTH];
    int            checks = 0, failures = 0;

    always #5 clock = ~clock;

    always_ff @(posedge clock) mem_data <= rom[mem_addr];

    jogo_sequencia_param #(.N(N), .DEPTH(DEPTH), .TIMEOUT(8), .T_MOSTRA(3)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .nivel_jogadas(nivel_jogadas),
        .chaves(chaves), .mem_addr(mem_addr), .mem_data(mem_data), .leds(leds),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado), .db_contagem(db_contagem), .db_rodada(db_rodada)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_estado(input logic [3:0] s);
        for (int i = 0; i < 40 && db_estado != s; i++) @(negedge clock);
        check("wait_estado", 32'(db_estado), 32'(s));
    endtask

    task automatic press(input logic [N-1:0] k);
        wait_estado(4'h3);
        chaves = k;
        repeat (2) @(negedge clock);
        chaves = '0;
    endtask

    task automatic start_game(input logic niv);
        iniciar = 1'b1;
        nivel_jogadas = niv;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; iniciar = 1'b0; nivel_jogadas = 1'b0; chaves = '0;
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;
        repeat (3) @(negedge clock);
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_flags", 32'({pronto, acertou, errou, timeout}), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_cnt", 32'({db_rodada, db_contagem, mem_addr}), 32'h0);

        reset = 1'b1; iniciar = 1'b1; nivel_jogadas = 1'b1;
        check("seq0", 32'(db_estado), 32'h0);
        @(negedge clock); check("seq1", 32'(db_estado), 32'h1); iniciar = 1'b0;
        @(negedge clock); check("seq2", 32'(db_estado), 32'h2);
        @(negedge clock); check("seq3", 32'(db_estado), 32'h3);
        iniciar = 1'b1;
        @(negedge clock); check("ign_iniciar", 32'(db_estado), 32'h3);
        iniciar = 1'b0;

        for (int r = 0; r < DEPTH; r++)
            for (int m = 0; m <= r; m++) press(rom[m]);
        @(negedge clock);
        check("win_estado", 32'(db_estado), 32'hA);
        check("win_flags", 32'({pronto, acertou, errou, timeout}), 32'b1100);
        check("win_rodada", 32'(db_rodada), 32'd3);
        repeat (5) @(negedge clock);
        check("win_hold", 32'({pronto, acertou, db_estado}), 32'h3A);

        start_game(1'b1);
        press(4'd1); press(4'd1); press(4'd4);
        @(negedge clock);
        check("err_estado", 32'(db_estado), 32'hE);
        check("err_flags", 32'({pronto, acertou, errou, timeout}), 32'b1010);
        check("err_leds", 32'(leds), 32'd4);
        check("err_pos", 32'({db_rodada, db_contagem}), 32'b0101);

        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("rst_game_estado", 32'(db_estado), 32'h1);
        check("rst_game_flags", 32'({pronto, acertou, errou, timeout}), 32'h0);
        check("rst_game_rodada", 32'(db_rodada), 32'h0);
        nivel_jogadas = 1'b0;
        press(4'd1); press(4'd1); press(4'd2);
        @(negedge clock);
        check("short_estado", 32'(db_estado), 32'hA);
        check("short_rodada", 32'({acertou, db_rodada}), 32'b101);

        rom[0] = 4'd3;
        start_game(1'b1);
        press(4'd3);
        @(negedge clock);
        check("inv_estado", 32'(db_estado), 32'hE);
        check("inv_errou", 32'({errou, leds}), 32'h13);
        rom[0] = 4'd1;

        start_game(1'b1);
        wait_estado(4'h3);
        repeat (7) @(negedge clock);
        check("to_before", 32'({timeout, db_estado}), 32'h03);
        @(negedge clock);
        check("to_estado", 32'(db_estado), 32'hD);
        check("to_flags", 32'({pronto, acertou, errou, timeout}), 32'b1001);

        start_game(1'b1);
        wait_estado(4'h3);
        repeat (7) @(negedge clock);
        chaves = 4'd1;
        @(negedge clock);
        check("late_press", 32'({timeout, db_estado}), 32'h04);
        repeat (19) @(negedge clock);
        chaves = '0;
        check("hold_estado", 32'(db_estado), 32'hD);
        check("hold_pos", 32'({db_rodada, db_contagem}), 32'b0100);
        check("hold_leds", 32'(leds), 32'd1);

        start_game(1'b1);
        press(4'd1);
        wait_estado(4'h3);
        #2 reset = 1'b0;
        #1;
        check("async_rst", 32'({db_estado, db_rodada, leds}), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("after_rst", 32'(db_estado), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
